// File: rtl/filter_loader_pkg.sv
// Shared widths, frame layout and enums for the serial coefficient/sample loader.
package filter_loader_pkg;

   localparam int DATA_W     = 16;
   localparam int ADDR_W     = 4;
   localparam int FRAME_BITS = 20;
   localparam int CNT_W      = 5;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

   typedef enum logic [ADDR_W-1:0] {
      ADDR_X  = 4'd0,
      ADDR_A1 = 4'd1,
      ADDR_B0 = 4'd2,
      ADDR_B1 = 4'd3
   } loader_addr_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } loader_state_t;

endpackage

// File: rtl/filter_loader_if.sv
// Host serial link plus the sample/coefficient outputs toward the IIR filter.
interface filter_loader_if;
   import filter_loader_pkg::*;

   logic              sclk;
   logic              cs_n;
   logic              mosi;
   logic [DATA_W-1:0] x;
   logic [DATA_W-1:0] a1;
   logic [DATA_W-1:0] b0;
   logic [DATA_W-1:0] b1;
   logic              x_valid;
   logic              frame_err;

   modport master (
      output sclk, cs_n, mosi,
      input  x, a1, b0, b1, x_valid, frame_err
   );

   modport slave (
      input  sclk, cs_n, mosi,
      output x, a1, b0, b1, x_valid, frame_err
   );

endinterface

// File: rtl/filter_loader_sync_edge.sv
// Multi-flop synchronizer with rise/fall pulses; RST_VAL sets the idle level held in reset.
module sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chain <= {STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], d};
         prev  <= chain[STAGES-1];
      end
   end

   assign q    = chain[STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;

endmodule

// File: rtl/filter_loader.sv
// Serial frame receiver: shifts {addr,data} frames in and drives x/a1/b0/b1 to the filter.
// Coefficients are staged in shadows and released together with the next sample.
//
// state | meaning
// IDLE  | waiting for cs_n fall (only once cs_n has been seen high since reset)
// SHIFT | shifting one bit per sclk rise until cs_n rises
// DONE  | one cycle: decode a 20-bit frame or flag it as bad
module filter_loader
   import filter_loader_pkg::*;
#(
   parameter int                SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] A1_RST      = '0,
   parameter logic [DATA_W-1:0] B0_RST      = '0,
   parameter logic [DATA_W-1:0] B1_RST      = '0
) (
   input logic            clk,
   input logic            rst,
   filter_loader_if.slave bus
);

   localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

   logic sclk_q, sclk_rise, sclk_fall;
   logic cs_q, cs_rise, cs_fall;
   logic unused_sync;

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .d(bus.sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst(rst), .d(bus.cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
   );

   assign unused_sync = sclk_q ^ sclk_fall;

   // mosi gets the same depth so it stays aligned with the synced sclk rise
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic [SETTLE_W-1:0]    settle;
   logic                   armed;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mosi_sync <= '0;
         settle    <= SETTLE_W'(SYNC_STAGES);
         armed     <= 1'b0;
      end else begin
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
         if (settle != '0) settle <= settle - 1'b1;
         // cs_n must be seen high through a flushed synchronizer before a frame may start
         if (settle == '0 && cs_q) armed <= 1'b1;
      end
   end

   loader_state_t state, state_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (armed && cs_fall) state_nxt = SHIFT;
         SHIFT:   if (cs_rise) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   logic [FRAME_BITS-1:0] shreg;
   logic [CNT_W-1:0]      count;
   loader_addr_t          frame_addr;
   logic [DATA_W-1:0]     frame_data;
   logic shift_en, load_x, load_a1, load_b0, load_b1, bad_frame;

   assign frame_addr = loader_addr_t'(shreg[FRAME_BITS-1:DATA_W]);
   assign frame_data = shreg[DATA_W-1:0];

   always_comb begin
      shift_en  = (state == SHIFT) && sclk_rise;
      load_x    = 1'b0;
      load_a1   = 1'b0;
      load_b0   = 1'b0;
      load_b1   = 1'b0;
      bad_frame = 1'b0;
      if (state == DONE) begin
         if (count == CNT_FULL) begin
            case (frame_addr)
               ADDR_X:  load_x    = 1'b1;
               ADDR_A1: load_a1   = 1'b1;
               ADDR_B0: load_b0   = 1'b1;
               ADDR_B1: load_b1   = 1'b1;
               default: bad_frame = 1'b1;
            endcase
         end else begin
            bad_frame = 1'b1;
         end
      end
   end

   logic [DATA_W-1:0] a1_sh, b0_sh, b1_sh;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg         <= '0;
         count         <= '0;
         a1_sh         <= A1_RST;
         b0_sh         <= B0_RST;
         b1_sh         <= B1_RST;
         bus.x         <= '0;
         bus.a1        <= A1_RST;
         bus.b0        <= B0_RST;
         bus.b1        <= B1_RST;
         bus.x_valid   <= 1'b0;
         bus.frame_err <= 1'b0;
      end else begin
         if (state == IDLE) begin
            count <= '0;
         end else if (shift_en) begin
            shreg <= {shreg[FRAME_BITS-2:0], mosi_sync[SYNC_STAGES-1]};
            if (count != CNT_SAT) count <= count + 1'b1;
         end
         if (load_a1) a1_sh <= frame_data;
         if (load_b0) b0_sh <= frame_data;
         if (load_b1) b1_sh <= frame_data;
         if (load_x) begin
            bus.x  <= frame_data;
            bus.a1 <= a1_sh;
            bus.b0 <= b0_sh;
            bus.b1 <= b1_sh;
         end
         bus.x_valid   <= load_x;
         bus.frame_err <= bad_frame;
      end
   end

endmodule

// File: tb/tb_filter_loader.sv
// Bench for filter_loader: directed scenarios then random frames against a frame-level model.
module tb_filter_loader;
   import filter_loader_pkg::*;

   localparam int          SYNC = 2;
   localparam logic [15:0] A1R  = 16'h1111;
   localparam logic [15:0] B0R  = 16'h2222;
   localparam logic [15:0] B1R  = 16'h3333;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   filter_loader_if bus();

   filter_loader #(
      .SYNC_STAGES(SYNC), .A1_RST(A1R), .B0_RST(B0R), .B1_RST(B1R)
   ) dut (
      .clk(clk), .rst(rst_n), .bus(bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int xv_cnt = 0, fe_cnt = 0, both_cnt = 0;
   int cyc = 0, rise_cyc = 0, last_xv_cyc = -1, last_fe_cyc = -1;
   logic [15:0] xq[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.x_valid) begin
         xv_cnt++;
         last_xv_cyc = cyc;
         xq.push_back(bus.x);
      end
      if (bus.frame_err) begin
         fe_cnt++;
         last_fe_cyc = cyc;
      end
      if (bus.x_valid && bus.frame_err) both_cnt++;
   end

   // frame-level reference: active and shadow banks plus expected pulse totals
   logic [15:0] mx, ma1, mb0, mb1, sa1, sb0, sb1;
   int exp_xv = 0, exp_fe = 0;
   logic [15:0] expq[$];

   task automatic model_reset();
      mx = 16'h0; ma1 = A1R; mb0 = B0R; mb1 = B1R;
      sa1 = A1R; sb0 = B0R; sb1 = B1R;
   endtask

   task automatic model_frame(input int nbits, input logic [19:0] word);
      if (nbits != 20) begin
         exp_fe++;
      end else begin
         case (int'(word[19:16]))
            0: begin
               mx = word[15:0]; ma1 = sa1; mb0 = sb0; mb1 = sb1;
               exp_xv++;
               expq.push_back(word[15:0]);
            end
            1: sa1 = word[15:0];
            2: sb0 = word[15:0];
            3: sb1 = word[15:0];
            default: exp_fe++;
         endcase
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [15:0] got, want;
      chk({tag, "_x"},  32'(bus.x),  32'(mx));
      chk({tag, "_a1"}, 32'(bus.a1), 32'(ma1));
      chk({tag, "_b0"}, 32'(bus.b0), 32'(mb0));
      chk({tag, "_b1"}, 32'(bus.b1), 32'(mb1));
      chk({tag, "_nvalid"}, 32'(xv_cnt), 32'(exp_xv));
      chk({tag, "_nerr"},   32'(fe_cnt), 32'(exp_fe));
      chk({tag, "_both"},   32'(both_cnt), 32'd0);
      chk({tag, "_nxq"},    32'(xq.size()), 32'(expq.size()));
      while (xq.size() > 0 && expq.size() > 0) begin
         got  = xq.pop_front();
         want = expq.pop_front();
         chk({tag, "_xseq"}, 32'(got), 32'(want));
      end
      xq.delete();
      expq.delete();
   endtask

   task automatic half_sclk();
      repeat (4) @(negedge clk);
   endtask

   // MSB first; bits past 20 use 'extra'; 'coincide' raises cs_n with the last sclk rise
   task automatic send_frame(input int nbits, input logic [19:0] word, input bit coincide,
                             input logic extra);
      bus.cs_n = 1'b0;
      half_sclk();
      half_sclk();
      for (int i = 0; i < nbits; i++) begin
         bus.mosi = (i < 20) ? word[19-i] : extra;
         half_sclk();
         bus.sclk = 1'b1;
         if (coincide && i == nbits - 1) begin
            bus.cs_n = 1'b1;
            rise_cyc = cyc;
            half_sclk();
            bus.sclk = 1'b0;
         end else begin
            half_sclk();
            bus.sclk = 1'b0;
         end
      end
      if (!coincide) begin
         half_sclk();
         bus.cs_n = 1'b1;
         rise_cyc = cyc;
      end
      half_sclk();
   endtask

   task automatic settle();
      repeat (SYNC + 6) @(negedge clk);
   endtask

   task automatic frame(input int nbits, input logic [19:0] word);
      send_frame(nbits, word, 1'b0, 1'b1);
      model_frame(nbits, word);
      settle();
   endtask

   initial begin
      int nb, sel;
      logic [3:0]  addr;
      logic [15:0] data;

      rst_n    = 1'b0;
      bus.sclk = 1'b0;
      bus.cs_n = 1'b1;
      bus.mosi = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_xvalid", 32'(bus.x_valid), 32'd0);
      chk("rst_ferr",   32'(bus.frame_err), 32'd0);
      check_all("rst");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // coefficients stay staged until the sample frame
      frame(20, {4'h1, 16'h3C00});
      check_all("t1_a1");
      frame(20, {4'h2, 16'h1234});
      check_all("t1_b0");
      frame(20, {4'h3, 16'hABCD});
      check_all("t1_b1");
      frame(20, {4'h0, 16'h0042});
      check_all("t1_x");
      chk("t1_latency", 32'(last_xv_cyc - rise_cyc), 32'(SYNC + 2));

      frame(19, {4'h0, 16'h5555});
      check_all("t2_short");
      chk("t2_latency", 32'(last_fe_cyc - rise_cyc), 32'(SYNC + 2));
      frame(20, {4'h0, 16'h0077});
      check_all("t2_recover");

      frame(21, {4'h1, 16'hDEAD});
      check_all("t3_long");

      frame(20, {4'h7, 16'hFFFF});
      check_all("t4_badaddr");
      frame(20, {4'h0, 16'h0099});
      check_all("t4_shadows");

      // reset mid-frame with cs_n held low across the release
      bus.cs_n = 1'b0;
      half_sclk();
      for (int i = 0; i < 10; i++) begin
         bus.mosi = 1'b1;
         half_sclk();
         bus.sclk = 1'b1;
         half_sclk();
         bus.sclk = 1'b0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      check_all("t5_reset");
      for (int i = 0; i < 12; i++) begin
         bus.mosi = i[0];
         half_sclk();
         bus.sclk = 1'b1;
         half_sclk();
         bus.sclk = 1'b0;
      end
      half_sclk();
      bus.cs_n = 1'b1;
      settle();
      check_all("t5_ignored");
      frame(20, {4'h0, 16'h0100});
      check_all("t5_after");

      // back-to-back samples, last sclk rise coincident with cs_n rise
      send_frame(20, {4'h0, 16'h0001}, 1'b1, 1'b0);
      model_frame(20, {4'h0, 16'h0001});
      send_frame(20, {4'h0, 16'h0002}, 1'b1, 1'b0);
      model_frame(20, {4'h0, 16'h0002});
      settle();
      check_all("t6_b2b");

      for (int k = 0; k < 25; k++) begin
         addr = 4'($urandom_range(0, 5));
         data = 16'($urandom);
         sel  = int'($urandom_range(0, 5));
         nb   = (sel == 0) ? 19 : (sel == 1) ? 21 : 20;
         send_frame(nb, {addr, data}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         model_frame(nb, {addr, data});
         settle();
         check_all($sformatf("rnd%0d", k));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
